// File: rtl/wbu_ctrl_if.sv
// EXU -> WBU retire handshake: one instruction offered per valid/ready transfer.
interface wbu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              wsel;
    logic [DATA_W-1:0] alu_result;

    modport master (
        output valid, pc, rd, wen, wsel, alu_result,
        input  ready
    );

    modport slave (
        input  valid, pc, rd, wen, wsel, alu_result,
        output ready
    );
endinterface

// File: rtl/wbu_ctrl.sv
// Writeback sequencer: latches a retiring instruction, waits for load data,
// then issues one register-file write and a commit pulse.
module wbu_ctrl #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    wbu_ctrl_if.slave         exu,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_rready_o,
    output logic              wsel_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] mem_result_o,
    output logic              wena_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic              commit_valid_o,
    output logic [DATA_W-1:0] commit_pc_o,
    output logic              timeout_o
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE, ERROR} state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t            state_reg;
    logic              ready_reg;
    logic              mem_rready_reg;
    logic              wena_reg;
    logic              commit_valid_reg;
    logic              wsel_reg;
    logic              wen_eff_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] mem_result_reg;
    logic [REG_AW-1:0] waddr_reg;
    logic [DATA_W-1:0] commit_pc_reg;
    logic              timeout_reg;
    logic [7:0]        cnt_reg;

    // Handshake and outputs are flops updated together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            ready_reg        <= 1'b1;
            mem_rready_reg   <= 1'b0;
            wena_reg         <= 1'b0;
            commit_valid_reg <= 1'b0;
            wsel_reg         <= 1'b0;
            wen_eff_reg      <= 1'b0;
            alu_result_reg   <= '0;
            mem_result_reg   <= '0;
            waddr_reg        <= '0;
            commit_pc_reg    <= '0;
            timeout_reg      <= 1'b0;
            cnt_reg          <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (exu.valid) begin
                        commit_pc_reg  <= exu.pc;
                        waddr_reg      <= exu.rd;
                        wen_eff_reg    <= exu.wen && (exu.rd != '0);
                        wsel_reg       <= exu.wsel;
                        alu_result_reg <= exu.alu_result;
                        ready_reg      <= 1'b0;
                        cnt_reg        <= '0;
                        if (!exu.wsel) begin
                            state_reg        <= WRITE;
                            wena_reg         <= exu.wen && (exu.rd != '0);
                            commit_valid_reg <= 1'b1;
                        end else begin
                            state_reg      <= WAIT_MEM;
                            mem_rready_reg <= 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    // A response on the last allowed cycle still wins over the timeout.
                    if (mem_rvalid_i) begin
                        mem_result_reg   <= mem_rdata_i;
                        cnt_reg          <= '0;
                        mem_rready_reg   <= 1'b0;
                        wena_reg         <= wen_eff_reg;
                        commit_valid_reg <= 1'b1;
                        state_reg        <= WRITE;
                    end else if (cnt_reg == TO_LAST) begin
                        timeout_reg    <= 1'b1;
                        mem_rready_reg <= 1'b0;
                        state_reg      <= ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                WRITE: begin
                    wena_reg         <= 1'b0;
                    commit_valid_reg <= 1'b0;
                    ready_reg        <= 1'b1;
                    state_reg        <= IDLE;
                end
                ERROR: begin
                    state_reg <= ERROR;
                end
                default: begin
                    state_reg        <= IDLE;
                    ready_reg        <= 1'b1;
                    mem_rready_reg   <= 1'b0;
                    wena_reg         <= 1'b0;
                    commit_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign exu.ready      = ready_reg;
    assign mem_rready_o   = mem_rready_reg;
    assign wsel_o         = wsel_reg;
    assign alu_result_o   = alu_result_reg;
    assign mem_result_o   = mem_result_reg;
    assign wena_o         = wena_reg;
    assign waddr_o        = waddr_reg;
    assign commit_valid_o = commit_valid_reg;
    assign commit_pc_o    = commit_pc_reg;
    assign timeout_o      = timeout_reg;
endmodule

// File: tb/tb_wbu_ctrl.sv
// Directed bench for wbu_ctrl with MEM_TIMEOUT=4; expectations are hand-computed.
module tb_wbu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_rready_o;
    logic        wsel_o;
    logic [31:0] alu_result_o;
    logic [31:0] mem_result_o;
    logic        wena_o;
    logic [4:0]  waddr_o;
    logic        commit_valid_o;
    logic [31:0] commit_pc_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    wbu_ctrl_if #(.DATA_W(32), .REG_AW(5)) exu_bus ();

    wbu_ctrl #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .exu            (exu_bus.slave),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_rready_o   (mem_rready_o),
        .wsel_o         (wsel_o),
        .alu_result_o   (alu_result_o),
        .mem_result_o   (mem_result_o),
        .wena_o         (wena_o),
        .waddr_o        (waddr_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic wsel, input logic [31:0] alu);
        exu_bus.valid      = 1'b1;
        exu_bus.pc         = pc;
        exu_bus.rd         = rd;
        exu_bus.wen        = wen;
        exu_bus.wsel       = wsel;
        exu_bus.alu_result = alu;
    endtask

    initial begin
        exu_bus.valid      = 1'b0;
        exu_bus.pc         = '0;
        exu_bus.rd         = '0;
        exu_bus.wen        = 1'b0;
        exu_bus.wsel       = 1'b0;
        exu_bus.alu_result = '0;

        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(exu_bus.ready), 32'd1);
        chk("rst_mem_rready", 32'(mem_rready_o), 32'd0);
        chk("rst_wena", 32'(wena_o), 32'd0);
        chk("rst_commit", 32'(commit_valid_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_alu", alu_result_o, 32'd0);
        chk("rst_pc", commit_pc_o, 32'd0);
        rst = 1'b1;
        tick();
        $display("txn reset: ready=%0d", exu_bus.ready);

        // 1. ALU op
        offer(32'h8000_0000, 5'd5, 1'b1, 1'b0, 32'h1234_5678);
        tick();
        exu_bus.valid = 1'b0;
        chk("alu_wena", 32'(wena_o), 32'd1);
        chk("alu_waddr", 32'(waddr_o), 32'd5);
        chk("alu_wsel", 32'(wsel_o), 32'd0);
        chk("alu_result", alu_result_o, 32'h1234_5678);
        chk("alu_commit", 32'(commit_valid_o), 32'd1);
        chk("alu_commit_pc", commit_pc_o, 32'h8000_0000);
        chk("alu_ready_write", 32'(exu_bus.ready), 32'd0);
        tick();
        chk("alu_idle_ready", 32'(exu_bus.ready), 32'd1);
        chk("alu_idle_commit", 32'(commit_valid_o), 32'd0);
        chk("alu_idle_wena", 32'(wena_o), 32'd0);
        $display("txn alu: pc=%h rd=5 result=%h", commit_pc_o, alu_result_o);

        // 3. x0 write suppressed, then wen=0 with valid held across WRITE
        offer(32'h0000_0100, 5'd0, 1'b1, 1'b0, 32'h0000_AAAA);
        tick();
        chk("x0_commit", 32'(commit_valid_o), 32'd1);
        chk("x0_wena", 32'(wena_o), 32'd0);
        offer(32'h0000_0104, 5'd7, 1'b0, 1'b0, 32'h0000_BBBB);
        tick();
        chk("held_idle_ready", 32'(exu_bus.ready), 32'd1);
        chk("held_idle_commit", 32'(commit_valid_o), 32'd0);
        tick();
        exu_bus.valid = 1'b0;
        chk("nowen_commit", 32'(commit_valid_o), 32'd1);
        chk("nowen_wena", 32'(wena_o), 32'd0);
        chk("nowen_waddr", 32'(waddr_o), 32'd7);
        chk("nowen_pc", commit_pc_o, 32'h0000_0104);
        chk("nowen_alu", alu_result_o, 32'h0000_BBBB);
        tick();
        $display("txn x0/nowen: both committed without write");

        // 2. Load, response on the last allowed WAIT_MEM cycle
        offer(32'h0000_0200, 5'd10, 1'b1, 1'b1, 32'h0000_0055);
        tick();
        exu_bus.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ld_mem_rready", 32'(mem_rready_o), 32'd1);
            chk("ld_ready", 32'(exu_bus.ready), 32'd0);
            chk("ld_wena_wait", 32'(wena_o), 32'd0);
            if (i == 3) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_rvalid_i = 1'b0;
        chk("ld_wena", 32'(wena_o), 32'd1);
        chk("ld_waddr", 32'(waddr_o), 32'd10);
        chk("ld_wsel", 32'(wsel_o), 32'd1);
        chk("ld_mem_result", mem_result_o, 32'hDEAD_BEEF);
        chk("ld_commit", 32'(commit_valid_o), 32'd1);
        chk("ld_no_timeout", 32'(timeout_o), 32'd0);
        chk("ld_mem_rready_wr", 32'(mem_rready_o), 32'd0);
        tick();
        chk("ld_idle_ready", 32'(exu_bus.ready), 32'd1);
        $display("txn load: rd=10 data=%h", mem_result_o);

        // 5. Spurious rvalid in IDLE and WRITE
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_1111;
        tick();
        chk("spur_idle_memres", mem_result_o, 32'hDEAD_BEEF);
        chk("spur_idle_ready", 32'(exu_bus.ready), 32'd1);
        offer(32'h0000_0300, 5'd3, 1'b1, 1'b0, 32'hCAFE_F00D);
        tick();
        exu_bus.valid = 1'b0;
        chk("spur_wena", 32'(wena_o), 32'd1);
        chk("spur_waddr", 32'(waddr_o), 32'd3);
        chk("spur_alu", alu_result_o, 32'hCAFE_F00D);
        chk("spur_wsel", 32'(wsel_o), 32'd0);
        chk("spur_memres", mem_result_o, 32'hDEAD_BEEF);
        tick();
        mem_rvalid_i = 1'b0;
        chk("spur_after_memres", mem_result_o, 32'hDEAD_BEEF);
        $display("txn spurious: mem_result=%h", mem_result_o);

        // 6. Reset during WAIT_MEM aborts the load
        offer(32'h0000_0400, 5'd9, 1'b1, 1'b1, 32'h0);
        tick();
        exu_bus.valid = 1'b0;
        tick();
        chk("abort_wait_rready", 32'(mem_rready_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(exu_bus.ready), 32'd1);
        chk("abort_mem_rready", 32'(mem_rready_o), 32'd0);
        chk("abort_memres", mem_result_o, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h2222_2222;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_commit", 32'(commit_valid_o), 32'd0);
        chk("abort_wena", 32'(wena_o), 32'd0);
        chk("abort_ready_rel", 32'(exu_bus.ready), 32'd1);
        chk("abort_memres_rel", mem_result_o, 32'd0);
        mem_rvalid_i = 1'b0;
        tick();
        $display("txn abort: no commit after reset");

        // 4. Timeout with no response
        offer(32'h0000_0500, 5'd4, 1'b1, 1'b1, 32'h0);
        tick();
        exu_bus.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_rready", 32'(mem_rready_o), 32'd1);
            chk("to_wait_flag", 32'(timeout_o), 32'd0);
            tick();
        end
        chk("to_flag", 32'(timeout_o), 32'd1);
        chk("to_ready", 32'(exu_bus.ready), 32'd0);
        chk("to_mem_rready", 32'(mem_rready_o), 32'd0);
        offer(32'h0000_0600, 5'd6, 1'b1, 1'b0, 32'h1);
        tick(); tick();
        chk("err_ready", 32'(exu_bus.ready), 32'd0);
        chk("err_commit", 32'(commit_valid_o), 32'd0);
        chk("err_wena", 32'(wena_o), 32'd0);
        chk("err_flag", 32'(timeout_o), 32'd1);
        exu_bus.valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("err_rst_flag", 32'(timeout_o), 32'd0);
        chk("err_rst_ready", 32'(exu_bus.ready), 32'd1);
        chk("err_rst_waddr", 32'(waddr_o), 32'd0);
        chk("err_rst_pc", commit_pc_o, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        $display("txn timeout: flag raised and cleared by reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
